// File: rtl/vga_timing_pkg.sv
// Shared timing defaults (640x480@60) and constant helpers for the raster timing generator.
package vga_timing_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int h_total(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    function automatic int v_total(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    // True when pos lies inside the sync pulse [start, start+len-1].
    function automatic logic sync_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered sync and active decode of the new position.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = 800,
    parameter int DISP  = 640,
    parameter int FRONT = 16,
    parameter int SYNC  = 96,
    parameter int POL   = 0,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         force_zero,
    output logic [W-1:0] pos,
    output logic         wrap,
    output logic         sync,
    output logic         active
);

    localparam logic         ACT  = (POL != 0);
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] pos_nxt;

    assign wrap = (pos == LAST);

    always_comb begin
        pos_nxt = pos + W'(1);
        if (force_zero || wrap) begin
            pos_nxt = '0;
        end
    end

    // Sync and active are decoded from pos_nxt so they line up with pos in the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos    <= LAST;
            sync   <= ~ACT;
            active <= 1'b0;
        end else if (step) begin
            pos    <= pos_nxt;
            sync   <= sync_window(int'(pos_nxt), DISP + FRONT, SYNC) ? ACT : ~ACT;
            active <= (int'(pos_nxt) < DISP);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with prescaler, run/freeze, genlock restart and start pulses.
// Optional frame counter enabled by defining VGA_TIMING_FRAMECNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = DEF_H_DISPLAY,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_DISPLAY  = DEF_V_DISPLAY,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CLK_DIV    = 1,
    parameter int H_W        = 10,
    parameter int V_W        = 10
`ifdef VGA_TIMING_FRAMECNT_EN
    ,
    parameter int FRAME_W    = 8
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           restart,
    output logic           pix_ce,
    output logic [H_W-1:0] hpos,
    output logic [V_W-1:0] vpos,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic           line_start,
    output logic           frame_start
`ifdef VGA_TIMING_FRAMECNT_EN
    ,
    output logic [FRAME_W-1:0] frame_cnt
`endif
);

    localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             restart_pend;
    logic             rst_req;
    logic             frame_adv;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_active;
    logic             v_active;

    assign tick      = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rst_req   = restart || restart_pend;
    assign frame_adv = rst_req || (h_wrap && v_wrap);

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .DISP  (H_DISPLAY),
        .FRONT (H_FRONT),
        .SYNC  (H_SYNC),
        .POL   (H_SYNC_POL),
        .W     (H_W)
    ) u_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (tick),
        .force_zero (rst_req),
        .pos        (hpos),
        .wrap       (h_wrap),
        .sync       (hsync),
        .active     (h_active)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .DISP  (V_DISPLAY),
        .FRONT (V_FRONT),
        .SYNC  (V_SYNC),
        .POL   (V_SYNC_POL),
        .W     (V_W)
    ) u_v (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (tick && (h_wrap || rst_req)),
        .force_zero (rst_req),
        .pos        (vpos),
        .wrap       (v_wrap),
        .sync       (vsync),
        .active     (v_active)
    );

    assign display_on = h_active && v_active;

    // A restart seen while frozen stays pending until the next tick consumes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            restart_pend <= 1'b0;
            pix_ce       <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            if (en) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            end
            if (tick) begin
                restart_pend <= 1'b0;
            end else if (restart) begin
                restart_pend <= 1'b1;
            end
            pix_ce      <= tick;
            line_start  <= tick && (h_wrap || rst_req);
            frame_start <= tick && frame_adv;
        end
    end

`ifdef VGA_TIMING_FRAMECNT_EN
    logic first_done;

    // The frame entered on the first tick after reset is not a completed frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            first_done <= 1'b0;
        end else if (tick && frame_adv) begin
            if (first_done) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
            first_done <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small raster (H 8/2/3/2, V 4/1/2/1), CLK_DIV 1 and 3.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n, en, restart;
    logic       rst3_n, en3, restart3;

    logic       pix_ce, hsync, vsync, display_on, line_start, frame_start;
    logic [3:0] hpos;
    logic [2:0] vpos;
    logic       pix_ce3, hsync3, vsync3, display_on3, line_start3, frame_start3;
    logic [3:0] hpos3;
    logic [2:0] vpos3;
`ifdef VGA_TIMING_FRAMECNT_EN
    logic [7:0] frame_cnt, frame_cnt3;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int idx;
    int fcnt;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .CLK_DIV(1), .H_W(4), .V_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .pix_ce(pix_ce), .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAMECNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .CLK_DIV(3), .H_W(4), .V_W(3)
    ) dut3 (
        .clk(clk), .rst_n(rst3_n), .en(en3), .restart(restart3),
        .pix_ce(pix_ce3), .hpos(hpos3), .vpos(vpos3), .hsync(hsync3), .vsync(vsync3),
        .display_on(display_on3), .line_start(line_start3), .frame_start(frame_start3)
`ifdef VGA_TIMING_FRAMECNT_EN
        , .frame_cnt(frame_cnt3)
`endif
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_hs(input int h);
        return !(h >= 10 && h <= 12);
    endfunction

    function automatic logic exp_vs(input int v);
        return !(v >= 5 && v <= 6);
    endfunction

    task automatic chk_px(input string tag, input int h, input int v,
                          input logic ce, input logic ls, input logic fs);
        chk({tag, ".hpos"},        32'(hpos),        h);
        chk({tag, ".vpos"},        32'(vpos),        v);
        chk({tag, ".hsync"},       32'(hsync),       32'(exp_hs(h)));
        chk({tag, ".vsync"},       32'(vsync),       32'(exp_vs(v)));
        chk({tag, ".display_on"},  32'(display_on),  32'(h < 8 && v < 4));
        chk({tag, ".pix_ce"},      32'(pix_ce),      32'(ce));
        chk({tag, ".line_start"},  32'(line_start),  32'(ls));
        chk({tag, ".frame_start"}, 32'(frame_start), 32'(fs));
    endtask

    task automatic chk_fcnt(input string tag);
`ifdef VGA_TIMING_FRAMECNT_EN
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), fcnt);
`else
        if (tag.len() == 0) chk("frame_cnt_tag", 32'(tag.len()), 1);
`endif
    endtask

    // Free-running advance of n pixels, tracking the expected raster index and frame count.
    task automatic advance(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            idx = (idx + 1) % 120;
            if (idx == 0) fcnt++;
            chk_px(tag, idx % 15, idx / 15, 1'b1, (idx % 15) == 0, idx == 0);
            chk_fcnt(tag);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; restart = 1'b0;
        rst3_n = 1'b0; en3 = 1'b0; restart3 = 1'b0;
        fcnt = 0;

        // Reset state: last back-porch pixel
        step(5);
        chk_px("reset", 14, 7, 1'b0, 1'b0, 1'b0);
        chk_fcnt("reset");

        rst_n = 1'b1; en = 1'b1;
        step(1);
        idx = 0;
        chk_px("first", 0, 0, 1'b1, 1'b1, 1'b1);
        chk_fcnt("first");

        // Two full frames
        advance("run", 240);

        // Freeze at hpos 5
        advance("to5", 5);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk_px("freeze", 5, 0, 1'b0, 1'b0, 1'b0);
        end
        en = 1'b1;
        advance("thaw", 1);

        // Restart at (9,3)
        advance("to93", 48);
        chk_px("at93", 9, 3, 1'b1, 1'b0, 1'b0);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        idx = 0; fcnt++;
        chk_px("restart", 0, 0, 1'b1, 1'b1, 1'b1);
        chk_fcnt("restart");

        // Restart requested while frozen
        advance("to2", 2);
        en = 1'b0; restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk_px("frzrst", 2, 0, 1'b0, 1'b0, 1'b0);
        step(3);
        chk_px("frzrst_hold", 2, 0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        step(1);
        idx = 0; fcnt++;
        chk_px("frzrst_apply", 0, 0, 1'b1, 1'b1, 1'b1);
        chk_fcnt("frzrst_apply");

        // Restart coinciding with the natural frame wrap
        advance("to_end", 119);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        idx = 0; fcnt++;
        chk_px("wraprst", 0, 0, 1'b1, 1'b1, 1'b1);
        chk_fcnt("wraprst");
        advance("after_wraprst", 1);

        // Reset mid-frame with both syncs active
        advance("to116", 100);
        chk_px("at116", 11, 6, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1);
        fcnt = 0;
        chk_px("midrst", 14, 7, 1'b0, 1'b0, 1'b0);
        chk_fcnt("midrst");
        rst_n = 1'b1;
        step(1);
        idx = 0;
        chk_px("midrst_first", 0, 0, 1'b1, 1'b1, 1'b1);
        chk_fcnt("midrst_first");

        // Prescaler CLK_DIV=3: one pixel every third clock
        rst3_n = 1'b1; en3 = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            int h, v;
            step(1);
            if (c < 3) begin
                h = 14; v = 7;
            end else begin
                h = ((c / 3) - 1) % 15; v = 0;
            end
            chk("div3.pix_ce",      32'(pix_ce3),      32'((c % 3) == 0));
            chk("div3.hpos",        32'(hpos3),        h);
            chk("div3.vpos",        32'(vpos3),        v);
            chk("div3.hsync",       32'(hsync3),       32'(exp_hs(h)));
            chk("div3.display_on",  32'(display_on3),  32'(h < 8 && v < 4));
            chk("div3.frame_start", 32'(frame_start3), 32'(c == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
